// File: rtl/pattern_generator.sv
// AXI-Stream test-pattern source: emits batches of fixed-length packets with
// selectable payload (packet number, number/beat, LFSR, walking one) and idle gaps.
module pattern_generator #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned GAP_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [63:0]               packet_count,
    input  logic [LEN_WIDTH-1:0]      packet_length,
    input  logic [GAP_WIDTH-1:0]      gap_cycles,
    input  logic [1:0]                mode,
    input  logic [31:0]               seed,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic [63:0]               packets_sent,
    output logic [DATA_WIDTH-1:0]     AXIS_TX_TDATA,
    output logic [DATA_WIDTH/8-1:0]   AXIS_TX_TKEEP,
    output logic                      AXIS_TX_TVALID,
    output logic                      AXIS_TX_TLAST,
    input  logic                      AXIS_TX_TREADY
);

    localparam int unsigned LANES     = DATA_WIDTH / 64;
    localparam int unsigned GB_W      = $clog2(DATA_WIDTH);
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t                 r_state;
    logic                   r_valid;
    logic                   r_pend_start;
    logic                   r_pend_abort;
    logic [63:0]            r_packet_num;
    logic [63:0]            r_packets_sent;
    logic [63:0]            r_remaining;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_beat;
    logic [GAP_WIDTH-1:0]   r_gap;
    logic [GAP_WIDTH-1:0]   r_gap_cnt;
    logic [1:0]             r_mode;
    logic [31:0]            r_lfsr;
    logic [GB_W-1:0]        r_gbeat;

    logic                   w_accept;
    logic                   w_last;
    logic [DATA_WIDTH-1:0]  w_tdata;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    assign w_accept = r_valid & AXIS_TX_TREADY;
    assign w_last   = (r_beat == r_len - LEN_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_valid        <= 1'b0;
            r_pend_start   <= 1'b0;
            r_pend_abort   <= 1'b0;
            r_packet_num   <= '0;
            r_packets_sent <= '0;
            r_remaining    <= '0;
            r_len          <= LEN_WIDTH'(4);
            r_beat         <= '0;
            r_gap          <= '0;
            r_gap_cnt      <= '0;
            r_mode         <= '0;
            r_lfsr         <= 32'd1;
            r_gbeat        <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_pend_start) begin
                        r_len          <= (packet_length == '0) ? LEN_WIDTH'(4) : packet_length;
                        r_gap          <= gap_cycles;
                        r_mode         <= mode;
                        r_lfsr         <= (seed == 32'd0) ? 32'd1 : seed;
                        r_remaining    <= packet_count;
                        r_packet_num   <= '0;
                        r_packets_sent <= '0;
                        r_beat         <= '0;
                        r_gbeat        <= '0;
                        r_pend_start   <= 1'b0;
                        r_pend_abort   <= 1'b0;
                        if (packet_count != 64'd0) begin
                            r_state <= S_SEND;
                            r_valid <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (w_accept) begin
                        r_lfsr  <= lfsr_step(r_lfsr);
                        r_gbeat <= (r_gbeat == GB_W'(DATA_WIDTH - 1)) ? '0 : r_gbeat + GB_W'(1);
                        if (w_last) begin
                            r_beat         <= '0;
                            r_packet_num   <= r_packet_num + 64'd1;
                            r_packets_sent <= r_packets_sent + 64'd1;
                            r_remaining    <= r_remaining - 64'd1;
                            // Batch ends here on last packet or any pending request
                            if (r_remaining == 64'd1 || r_pend_abort || r_pend_start) begin
                                r_valid      <= 1'b0;
                                r_state      <= S_IDLE;
                                r_pend_abort <= 1'b0;
                            end else if (r_gap != '0) begin
                                r_valid   <= 1'b0;
                                r_state   <= S_GAP;
                                r_gap_cnt <= r_gap;
                            end
                        end else begin
                            r_beat <= r_beat + LEN_WIDTH'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (r_pend_abort || r_pend_start) begin
                        r_state      <= S_IDLE;
                        r_pend_abort <= 1'b0;
                    end else if (r_gap_cnt == GAP_WIDTH'(1)) begin
                        r_valid <= 1'b1;
                        r_state <= S_SEND;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase

            // Fresh pulses take precedence over the launch/boundary clears above
            if (abort) begin
                r_pend_abort <= 1'b1;
                r_pend_start <= 1'b0;
            end else if (start) begin
                r_pend_start <= 1'b1;
            end
        end
    end

    // Payload is a pure function of registered state, so it holds during stalls
    always_comb begin
        w_tdata = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            case (r_mode)
                2'd0:    w_tdata[i*64 +: 64] = r_packet_num;
                2'd1:    w_tdata[i*64 +: 64] = {r_packet_num[31:0], 32'(r_beat)};
                2'd2:    w_tdata[i*64 +: 64] = {r_lfsr, ~r_lfsr};
                default: w_tdata[i*64 +: 64] = 64'd0;
            endcase
        end
        if (r_mode == 2'd3) begin
            w_tdata[r_gbeat] = 1'b1;
        end
    end

    assign busy           = (r_state != S_IDLE) | r_pend_start;
    assign packets_sent   = r_packets_sent;
    assign AXIS_TX_TDATA  = w_tdata;
    assign AXIS_TX_TKEEP  = '1;
    assign AXIS_TX_TVALID = r_valid;
    assign AXIS_TX_TLAST  = r_valid & w_last;

endmodule
